etc_pixel_scheduler: RTL

Block-to-pixel scheduler sitting between the compressed-block source and `etc_rgb_decoder`. It buffers incoming ETC2 blocks, issues pixel indices to the decoder `LANES` at a time in a selectable order, and tags each decoded result with image coordinates. It also tracks block position across a frame, replacing the hand-driven `pixIdx` sequencing used so far.

---
 rtl/etc_pixel_scheduler.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/etc_pixel_scheduler.sv
// Block-to-pixel scheduler: buffers ETC2 blocks, issues pixel indices to the
// decoder in column- or row-major order and tags each result with coordinates.
module etc_pixel_scheduler #(
    parameter int BLOCK_W    = 64,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int DEC_LAT    = 2
) (
    input  logic                sclk,
    input  logic                rsrt,
    input  logic [11:0]         cfg_blk_w_m1,
    input  logic [11:0]         cfg_blk_h_m1,
    input  logic                cfg_row_major,
    input  logic [BLOCK_W-1:0]  blk_data,
    input  logic                blk_rts,
    output logic                blk_rtr,
    output logic [BLOCK_W-1:0]  dec_block,
    output logic [4*LANES-1:0]  dec_pixIdx,
    output logic                dec_rtr,
    input  logic                dec_rts,
    input  logic [32*LANES-1:0] dec_rgba,
    output logic                pix_rts,
    output logic [32*LANES-1:0] pix_rgba,
    output logic [13:0]         pix_x,
    output logic [13:0]         pix_y,
    output logic                pix_blk_last,
    output logic                frame_done,
    output logic                tag_err
);

    localparam int GROUPS = 16 / LANES;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [13:0] x;
        logic [13:0] y;
        logic        blk_last;
        logic        frame_last;
    } tag_t;

    logic [BLOCK_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        count_nxt;
    logic               rdy_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         g;
    logic               g_last;

    logic [11:0]        bx;
    logic [11:0]        by;
    logic [11:0]        w_q;
    logic [11:0]        h_q;
    logic               row_q;
    logic [11:0]        w_eff;
    logic [11:0]        h_eff;
    logic               row_eff;
    logic               frame_start;
    logic               at_w;
    logic               at_h;

    logic [3:0]         k0;
    logic [3:0]         k;
    logic [1:0]         px0;
    logic [1:0]         py0;

    tag_t               tag_in;
    tag_t               tag_out;
    tag_t               tag_pipe [DEC_LAT];
    logic               fwd;

    // ---------------- block FIFO ----------------
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // rdy_q keeps blk_rtr low while in reset and for the release cycle
    assign blk_rtr = rdy_q & ~full;
    assign push    = blk_rts & blk_rtr;
    assign pop     = dec_rtr & g_last;

    assign dec_block = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (push)
            mem[wr_ptr] <= blk_data;
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // ---------------- issue FSM ----------------
    assign dec_rtr = (state == S_ISSUE);
    assign g_last  = (g == 4'(GROUPS - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (count_nxt != '0)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (g_last && count_nxt == '0)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state <= S_IDLE;
            g     <= '0;
        end else begin
            state <= state_nxt;
            if (dec_rtr)
                g <= g_last ? '0 : g + 1'b1;
        end
    end

    // ---------------- frame position ----------------
    // Config is live on the first group of a frame, then held.
    assign frame_start = dec_rtr & (g == '0) & (bx == '0) & (by == '0);
    assign w_eff       = frame_start ? cfg_blk_w_m1 : w_q;
    assign h_eff       = frame_start ? cfg_blk_h_m1 : h_q;
    assign row_eff     = frame_start ? cfg_row_major : row_q;
    assign at_w        = (bx == w_eff);
    assign at_h        = (by == h_eff);

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            bx    <= '0;
            by    <= '0;
            w_q   <= '0;
            h_q   <= '0;
            row_q <= 1'b0;
        end else begin
            if (frame_start) begin
                w_q   <= cfg_blk_w_m1;
                h_q   <= cfg_blk_h_m1;
                row_q <= cfg_row_major;
            end
            if (pop) begin
                if (at_w) begin
                    bx <= '0;
                    by <= at_h ? '0 : by + 1'b1;
                end else begin
                    bx <= bx + 1'b1;
                end
            end
        end
    end

    // ---------------- lane mapping ----------------
    assign k0 = 4'(int'(g) * LANES);

    always_comb begin
        px0 = k0[3:2];
        py0 = k0[1:0];
        unique case (1'b1)
            row_eff: begin
                px0 = k0[1:0];
                py0 = k0[3:2];
            end
            default: begin
                px0 = k0[3:2];
                py0 = k0[1:0];
            end
        endcase
    end

    always_comb begin
        dec_pixIdx = '0;
        k          = '0;
        if (dec_rtr) begin
            for (int l = 0; l < LANES; l++) begin
                k = 4'(int'(g) * LANES + l);
                dec_pixIdx[4*l +: 4] = row_eff ? {k[1:0], k[3:2]} : k;
            end
        end
    end

    // ---------------- tag pipe ----------------
    always_comb begin
        tag_in            = '0;
        tag_in.valid      = dec_rtr;
        tag_in.x          = {bx, px0};
        tag_in.y          = {by, py0};
        tag_in.blk_last   = dec_rtr & g_last;
        tag_in.frame_last = dec_rtr & g_last & at_w & at_h;
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            for (int i = 0; i < DEC_LAT; i++)
                tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < DEC_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[DEC_LAT-1];
    assign fwd     = dec_rts & tag_out.valid;

    // ---------------- output stage ----------------
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            pix_rts      <= 1'b0;
            pix_rgba     <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_blk_last <= 1'b0;
            frame_done   <= 1'b0;
            tag_err      <= 1'b0;
        end else begin
            pix_rts      <= fwd;
            pix_blk_last <= fwd & tag_out.blk_last;
            frame_done   <= fwd & tag_out.frame_last;
            if (fwd) begin
                pix_rgba <= dec_rgba;
                pix_x    <= tag_out.x;
                pix_y    <= tag_out.y;
            end
            if (dec_rts != tag_out.valid)
                tag_err <= 1'b1;
        end
    end

endmodule
